// File: rtl/gemmm2s_axis_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SRC AXI-Stream sources onto one master port.
// Output beats pass through a 2-entry skid buffer so downstream ready never reaches a source combinationally.
module gemmm2s_axis_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]            S_AXIS_TLAST,
    input  logic [NUM_SRC-1:0]            S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]            S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
    output logic                          M_AXIS_TLAST,
    output logic [((NUM_SRC > 1) ? $clog2(NUM_SRC) : 1)-1:0] M_AXIS_TID,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic                          BUSY
);

    localparam int ID_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                state;
    // grant doubles as last_grant: it keeps the previous winner while idle
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH-1:0]   next_grant;
    logic                  ready_q;

    logic [1:0]            occ;
    logic [1:0]            occ_next;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [ID_WIDTH-1:0]   head_id;
    logic [DATA_WIDTH-1:0] sec_data;
    logic                  sec_last;
    logic [ID_WIDTH-1:0]   sec_id;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_last;

    // Descending scan so the smallest offset after the last winner overrides the others
    always_comb begin
        int idx;
        idx        = 0;
        next_grant = grant;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(grant) + k) % NUM_SRC;
            if (S_AXIS_TVALID[idx]) begin
                next_grant = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        S_AXIS_TREADY = '0;
        if (state == ST_BUSY && ready_q) begin
            S_AXIS_TREADY[grant] = 1'b1;
        end
    end

    assign push    = |(S_AXIS_TVALID & S_AXIS_TREADY);
    assign pop     = (occ != 2'd0) && M_AXIS_TREADY;
    assign in_data = S_AXIS_TDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign in_last = S_AXIS_TLAST[grant];

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (!push && pop) begin
            occ_next = occ - 2'd1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
            grant <= ID_WIDTH'(NUM_SRC - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|S_AXIS_TVALID) begin
                        grant <= next_grant;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (push && in_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready looks one cycle ahead so a push can never land on a full buffer
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            occ       <= 2'd0;
            ready_q   <= 1'b0;
            head_data <= '0;
            head_last <= 1'b0;
            head_id   <= '0;
            sec_data  <= '0;
            sec_last  <= 1'b0;
            sec_id    <= '0;
        end else begin
            occ     <= occ_next;
            ready_q <= (occ_next < 2'd2);
            if (pop) begin
                if (occ == 2'd2) begin
                    head_data <= sec_data;
                    head_last <= sec_last;
                    head_id   <= sec_id;
                    if (push) begin
                        sec_data <= in_data;
                        sec_last <= in_last;
                        sec_id   <= grant;
                    end
                end else if (push) begin
                    head_data <= in_data;
                    head_last <= in_last;
                    head_id   <= grant;
                end
            end else if (push) begin
                if (occ == 2'd0) begin
                    head_data <= in_data;
                    head_last <= in_last;
                    head_id   <= grant;
                end else begin
                    sec_data <= in_data;
                    sec_last <= in_last;
                    sec_id   <= grant;
                end
            end
        end
    end

    assign M_AXIS_TDATA  = head_data;
    assign M_AXIS_TLAST  = head_last;
    assign M_AXIS_TID    = head_id;
    assign M_AXIS_TVALID = (occ != 2'd0);
    assign BUSY          = (state == ST_BUSY);

endmodule

// File: tb/tb_gemmm2s_axis_arbiter.sv
// Directed bench for gemmm2s_axis_arbiter with four sources: a cycle vector table for
// arbitration/skid timing plus packet-level traffic runs checked against a round-robin model.
module tb_gemmm2s_axis_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;

    logic             ACLK;
    logic             ARESETN;
    logic [NS*DW-1:0] s_tdata;
    logic [NS-1:0]    s_tlast;
    logic [NS-1:0]    s_tvalid;
    logic [NS-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic             m_tlast;
    logic [1:0]       m_tid;
    logic             m_tvalid;
    logic             m_tready;
    logic             busy;

    int errors = 0;
    int checks = 0;

    gemmm2s_axis_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .S_AXIS_TDATA(s_tdata),
        .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata),
        .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TID(m_tid),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TREADY(m_tready),
        .BUSY(busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [3:0] tvalid;
        logic       m_ready;
        logic [3:0] exp_tready;
        logic       exp_mvalid;
        logic [1:0] exp_tid;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[15];

    int plen[NS], npkt[NS], gap_at[NS], gap_len[NS], gap_cnt[NS], beat[NS], pkt[NS];
    int ready_mode, cyc, first_fire, last_fire, src1_early, multi_ready;
    logic [31:0] out_data[$];
    logic [1:0]  out_tid[$];
    logic        out_last[$];
    logic [31:0] exp_data[$];
    logic [1:0]  exp_tid[$];
    logic        exp_last[$];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input int s, input int p, input int b);
        return {4'(s), 4'h0, 8'(p), 16'(b)};
    endfunction

    task automatic apply_reset();
        ARESETN  = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    task automatic setup_traffic(input int mode);
        for (int s = 0; s < NS; s++) begin
            plen[s] = 1; npkt[s] = 0; gap_at[s] = 0; gap_len[s] = 0;
            gap_cnt[s] = 0; beat[s] = 0; pkt[s] = 0;
        end
        ready_mode = mode;
        out_data.delete(); out_tid.delete(); out_last.delete();
        exp_data.delete(); exp_tid.delete(); exp_last.delete();
    endtask

    // Packet-level round robin starting after source NS-1, assuming every pending source requests
    task automatic build_expected();
        int rem[NS];
        int last, sel, left;
        last = NS - 1;
        left = 0;
        for (int s = 0; s < NS; s++) begin rem[s] = npkt[s]; left += npkt[s]; end
        while (left > 0) begin
            sel = -1;
            for (int k = NS; k >= 1; k--) if (rem[(last + k) % NS] > 0) sel = (last + k) % NS;
            for (int b = 0; b < plen[sel]; b++) begin
                exp_data.push_back(beat_data(sel, npkt[sel] - rem[sel], b));
                exp_tid.push_back(2'(sel));
                exp_last.push_back(b == plen[sel] - 1);
            end
            rem[sel]--;
            left--;
            last = sel;
        end
    endtask

    task automatic apply_stimulus();
        for (int s = 0; s < NS; s++) begin
            s_tvalid[s] = 1'b0;
            if (pkt[s] < npkt[s]) begin
                if (gap_len[s] > 0 && beat[s] == gap_at[s] && gap_cnt[s] < gap_len[s]) gap_cnt[s]++;
                else s_tvalid[s] = 1'b1;
            end
            s_tdata[s*DW +: DW] = beat_data(s, pkt[s], beat[s]);
            s_tlast[s] = (beat[s] == plen[s] - 1);
        end
        m_tready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    endtask

    task automatic run_traffic(input int max_cycles, input int abort_beats);
        logic [NS-1:0] fire;
        logic          stall;
        logic [31:0]   held;
        int            total_in;
        stall = 1'b0; held = '0; total_in = 0;
        cyc = 0; first_fire = -1; last_fire = -1; src1_early = 0; multi_ready = 0;
        apply_stimulus();
        while (cyc < max_cycles && (abort_beats > 0 || out_data.size() < exp_data.size())) begin
            @(negedge ACLK);
            fire = s_tvalid & s_tready;
            if ($countones(s_tready) > 1) multi_ready++;
            if (s_tready[1] && pkt[0] < npkt[0]) src1_early++;
            if (stall) begin
                check_output("stall_valid", 32'(m_tvalid), 32'd1);
                check_output("stall_data", m_tdata, held);
            end
            stall = m_tvalid && !m_tready;
            held  = m_tdata;
            if (m_tvalid && m_tready) begin
                out_data.push_back(m_tdata);
                out_tid.push_back(m_tid);
                out_last.push_back(m_tlast);
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
            @(posedge ACLK);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (fire[s]) begin
                    total_in++;
                    beat[s]++;
                    if (beat[s] == plen[s]) begin beat[s] = 0; pkt[s]++; end
                end
            end
            if (abort_beats > 0 && total_in >= abort_beats) return;
            cyc++;
            apply_stimulus();
        end
        check_output("traffic_done", 32'(cyc < max_cycles), 32'd1);
    endtask

    task automatic compare_log(input string name);
        check_output({name, "_count"}, 32'(out_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < out_data.size() && i < exp_data.size(); i++) begin
            check_output($sformatf("%s_data%0d", name, i), out_data[i], exp_data[i]);
            check_output($sformatf("%s_tid%0d", name, i), 32'(out_tid[i]), 32'(exp_tid[i]));
            check_output($sformatf("%s_last%0d", name, i), 32'(out_last[i]), 32'(exp_last[i]));
        end
        check_output({name, "_onehot"}, 32'(multi_ready), 32'd0);
    endtask

    initial begin
        // tvalid, m_ready | tready, mvalid, tid, busy  (sampled #1 after each edge)
        vecs[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b1};
        vecs[1]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{4'hF, 1'b1, 4'h2, 1'b0, 2'd0, 1'b1};
        vecs[3]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{4'hF, 1'b1, 4'h4, 1'b0, 2'd0, 1'b1};
        vecs[5]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0};
        vecs[6]  = '{4'hF, 1'b1, 4'h8, 1'b0, 2'd0, 1'b1};
        vecs[7]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 1'b0};
        vecs[8]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 1'b1};
        vecs[9]  = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{4'hF, 1'b0, 4'h2, 1'b1, 2'd0, 1'b1};
        vecs[11] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 1'b0};
        vecs[12] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1};
        vecs[13] = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 1'b1};
        vecs[14] = '{4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0};

        ARESETN  = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '1;
        s_tlast  = '1;
        for (int s = 0; s < NS; s++) s_tdata[s*DW +: DW] = 32'hA000_0000 + 32'(s);
        repeat (3) @(posedge ACLK);
        #1;
        check_output("rst_tready", 32'(s_tready), 32'd0);
        check_output("rst_mvalid", 32'(m_tvalid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_mdata", m_tdata, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        for (int i = 0; i < 15; i++) begin
            s_tvalid = vecs[i].tvalid;
            m_tready = vecs[i].m_ready;
            @(posedge ACLK);
            #1;
            check_output($sformatf("vec%0d_tready", i), 32'(s_tready), 32'(vecs[i].exp_tready));
            check_output($sformatf("vec%0d_mvalid", i), 32'(m_tvalid), 32'(vecs[i].exp_mvalid));
            check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            if (vecs[i].exp_mvalid) begin
                check_output($sformatf("vec%0d_tid", i), 32'(m_tid), 32'(vecs[i].exp_tid));
                check_output($sformatf("vec%0d_data", i), m_tdata, 32'hA000_0000 + 32'(vecs[i].exp_tid));
            end
        end

        // Two sources streaming back-to-back 4-beat packets
        apply_reset();
        setup_traffic(0);
        plen[0] = 4; npkt[0] = 2; plen[1] = 4; npkt[1] = 2;
        build_expected();
        run_traffic(300, 0);
        compare_log("fair");
        check_output("fair_span", 32'(last_fire - first_fire + 1), 32'd19);

        // 8-beat packet from src1 under a 1,0,0 downstream ready pattern
        apply_reset();
        setup_traffic(1);
        plen[1] = 8; npkt[1] = 1;
        build_expected();
        run_traffic(300, 0);
        compare_log("bp");

        // src0 stalls 5 cycles mid-packet while src1 waits
        apply_reset();
        setup_traffic(0);
        plen[0] = 6; npkt[0] = 1; gap_at[0] = 2; gap_len[0] = 5;
        plen[1] = 3; npkt[1] = 1;
        build_expected();
        run_traffic(300, 0);
        compare_log("gap");
        check_output("gap_src1_early", 32'(src1_early), 32'd0);

        // Reset asserted after three beats of an 8-beat packet
        apply_reset();
        setup_traffic(0);
        plen[0] = 8; npkt[0] = 1; plen[1] = 2; npkt[1] = 1;
        run_traffic(300, 3);
        check_output("mid_mvalid_before", 32'(m_tvalid), 32'd1);
        ARESETN = 1'b0;
        #1;
        check_output("mid_mvalid", 32'(m_tvalid), 32'd0);
        check_output("mid_tready", 32'(s_tready), 32'd0);
        check_output("mid_busy", 32'(busy), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        check_output("mid_regrant", 32'(s_tready), 32'd1);
        check_output("mid_regrant_busy", 32'(busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
